// File: rtl/elementwise_sequencer_if.sv
// Command, SRAM, elementwise-unit and status signals of the elementwise sequencer.
// The sequencer takes the slave side; the requester and memories sit on the master side.
interface elementwise_sequencer_if #(
  parameter int AW = 8,
  parameter int LW = 9
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_func;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  logic          eu_en;
  logic [3:0]    eu_func;
  logic [31:0]   eu_in;
  logic [31:0]   eu_out;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic          busy;
  logic          done;
  logic          err;

  modport slave (
    input  cmd_valid, cmd_func, cmd_src, cmd_dst, cmd_len, rd_data, eu_out,
    output cmd_ready, rd_en, rd_addr, eu_en, eu_func, eu_in,
           wr_en, wr_addr, wr_data, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_func, cmd_src, cmd_dst, cmd_len, rd_data, eu_out,
    input  cmd_ready, rd_en, rd_addr, eu_en, eu_func, eu_in,
           wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/elementwise_sequencer.sv
// Streams accumulator words through the 1-cycle elementwise unit into the unified buffer,
// one job at a time: read -> unit -> write, one element per cycle, 3 cycles overhead per job.
module elementwise_sequencer #(
  parameter int AW = 8,
  parameter int LW = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  elementwise_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0]    FUNC_PASS = 4'b0001;
  localparam logic [3:0]    FUNC_RELU = 4'b0010;
  localparam logic [LW-1:0] LEN_ONE   = LW'(1);

  state_e        state_q,  state_d;
  logic [3:0]    func_q,   func_d;
  logic [AW-1:0] src_q,    src_d;
  logic [AW-1:0] dst_q,    dst_d;
  logic [LW-1:0] len_q,    len_d;
  logic [LW-1:0] rd_idx_q, rd_idx_d;
  logic [LW-1:0] wr_idx_q, wr_idx_d;
  logic          s1_v_q,   s1_v_d;
  logic          s2_v_q,   s2_v_d;
  logic          err_q,    err_d;

  logic accept;
  logic func_ok;
  logic last_rd;
  logic last_wr;

  assign accept  = bus.cmd_valid && (state_q == IDLE);
  assign func_ok = (bus.cmd_func == FUNC_PASS) || (bus.cmd_func == FUNC_RELU);
  assign last_rd = (rd_idx_q == len_q - LEN_ONE);
  assign last_wr = (wr_idx_q == len_q - LEN_ONE);

  // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = s2_v_q ? wr_idx_q + LEN_ONE : wr_idx_q;
    err_d    = err_q;
    // Stage 1 holds the element whose read strobe was up last cycle; stage 2 follows it.
    s1_v_d   = (state_q == READ);
    s2_v_d   = s1_v_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          func_d   = bus.cmd_func;
          src_d    = bus.cmd_src;
          dst_d    = bus.cmd_dst;
          len_d    = bus.cmd_len;
          rd_idx_d = '0;
          wr_idx_d = '0;
          err_d    = !func_ok;
          state_d  = (func_ok && (bus.cmd_len != '0)) ? READ : DONE;
        end
      end
      READ: begin
        rd_idx_d = rd_idx_q + LEN_ONE;
        if (last_rd) state_d = DRAIN;
      end
      DRAIN: begin
        if (s2_v_q && last_wr) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      func_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      err_q    <= err_d;
    end
  end

  // Datapath outputs are zero on bubbles so the unit and buffer never see stale operands.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rd_en     = (state_q == READ);
  assign bus.rd_addr   = bus.rd_en ? src_q + AW'(rd_idx_q) : '0;
  assign bus.eu_en     = s1_v_q;
  assign bus.eu_func   = (state_q != IDLE) ? func_q : '0;
  assign bus.eu_in     = s1_v_q ? bus.rd_data : '0;
  assign bus.wr_en     = s2_v_q;
  assign bus.wr_addr   = s2_v_q ? dst_q + AW'(wr_idx_q) : '0;
  assign bus.wr_data   = s2_v_q ? bus.eu_out : '0;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_elementwise_sequencer.sv
// Bench for elementwise_sequencer: models the accumulator SRAM and elementwise unit and
// checks every cycle of each job against per-element timing and data derived from the job.
module tb_elementwise_sequencer;
  localparam int AW = 8;
  localparam int LW = 9;

  typedef struct {
    logic [3:0]    func;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [LW-1:0] len;
  } job_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  elementwise_sequencer_if #(.AW(AW), .LW(LW)) bus();
  elementwise_sequencer #(.AW(AW), .LW(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] acc_mem [256];

  function automatic logic [31:0] eu_ref(input logic [3:0] f, input logic [31:0] x);
    case (f)
      4'b0001: return x;
      4'b0010: return ($signed(x) < 0) ? 32'd0 : x;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) bus.rd_data <= 32'd0;
    else if (bus.rd_en) bus.rd_data <= acc_mem[bus.rd_addr];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) bus.eu_out <= 32'd0;
    else bus.eu_out <= bus.eu_en ? eu_ref(bus.eu_func, bus.eu_in) : 32'd0;
  end

  task automatic drive_cmd(input job_t j);
    bus.cmd_valid = 1'b1;
    bus.cmd_func  = j.func;
    bus.cmd_src   = j.src;
    bus.cmd_dst   = j.dst;
    bus.cmd_len   = j.len;
  endtask

  // Waits for the handshake, then checks cycles T+1 .. T+N+1 against the job's expected timeline.
  task automatic run_job(input string tag, input job_t j, input bit chain, input job_t nxt,
                         output int waited);
    bit ok_func, active;
    int len, n_end;
    logic [6:0] ctrl_got, ctrl_exp;
    logic [AW-1:0] a_exp;
    logic [31:0] d_exp;
    waited = 0;
    while (!(bus.cmd_valid && bus.cmd_ready)) begin
      if (waited >= 60) begin
        total++; bad++;
        $display("FAIL %s handshake_timeout: waited=%0d cycles, required accept within 60", tag, waited);
        return;
      end
      @(negedge clk);
      waited++;
    end
    ok_func = (j.func == 4'b0001) || (j.func == 4'b0010);
    len     = int'(j.len);
    active  = ok_func && (len != 0);
    n_end   = active ? len + 3 : 1;
    for (int n = 1; n <= n_end + 1; n++) begin
      @(negedge clk);
      ctrl_exp = {active && n <= len,
                  active && n >= 2 && n <= len + 1,
                  active && n >= 3 && n <= len + 2,
                  n <= n_end,
                  n == n_end,
                  (n == n_end) && !ok_func,
                  n > n_end};
      ctrl_got = {bus.rd_en, bus.eu_en, bus.wr_en, bus.busy, bus.done, bus.err, bus.cmd_ready};
      total++;
      if (ctrl_got !== ctrl_exp) begin
        bad++;
        $display("FAIL %s ctrl{rd,eu,wr,busy,done,err,ready} T+%0d: got=%b want=%b", tag, n, ctrl_got, ctrl_exp);
      end
      total++;
      if (bus.eu_func !== ((n <= n_end) ? j.func : 4'd0)) begin
        bad++;
        $display("FAIL %s eu_func T+%0d: got=%h want=%h", tag, n, bus.eu_func, (n <= n_end) ? j.func : 4'd0);
      end
      if (ctrl_exp[6]) begin
        a_exp = j.src + AW'(n - 1);
        total++;
        if (bus.rd_addr !== a_exp) begin
          bad++;
          $display("FAIL %s rd_addr T+%0d: got=%h want=%h", tag, n, bus.rd_addr, a_exp);
        end
      end
      if (ctrl_exp[5]) begin
        d_exp = acc_mem[j.src + AW'(n - 2)];
        total++;
        if (bus.eu_in !== d_exp) begin
          bad++;
          $display("FAIL %s eu_in T+%0d: got=%h want=%h", tag, n, bus.eu_in, d_exp);
        end
      end
      if (ctrl_exp[4]) begin
        a_exp = j.dst + AW'(n - 3);
        d_exp = eu_ref(j.func, acc_mem[j.src + AW'(n - 3)]);
        total++;
        if (bus.wr_addr !== a_exp || bus.wr_data !== d_exp) begin
          bad++;
          $display("FAIL %s write T+%0d: got addr=%h data=%h want addr=%h data=%h",
                   tag, n, bus.wr_addr, bus.wr_data, a_exp, d_exp);
        end
      end
      if (n == 1) begin
        if (chain) drive_cmd(nxt);
        else bus.cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({bus.cmd_ready, bus.rd_en, bus.eu_en, bus.wr_en, bus.busy, bus.done, bus.err} !== 7'b1000000 ||
        bus.rd_addr !== '0 || bus.wr_addr !== '0 || bus.eu_func !== 4'd0) begin
      bad++;
      $display("FAIL reset_state: got ready=%b rd=%b eu=%b wr=%b busy=%b done=%b err=%b want ready=1 others=0",
               bus.cmd_ready, bus.rd_en, bus.eu_en, bus.wr_en, bus.busy, bus.done, bus.err);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got ready=%b busy=%b want ready=1 busy=0", bus.cmd_ready, bus.busy);
    end
  endtask

  task automatic test_pass();
    job_t j, none;
    int w;
    j = '{func: 4'b0001, src: 8'h10, dst: 8'h40, len: 9'd4};
    none = j;
    acc_mem[8'h10] = 32'd5;
    acc_mem[8'h11] = -32'sd7;
    acc_mem[8'h12] = 32'd0;
    acc_mem[8'h13] = 32'h7FFF_FFFF;
    drive_cmd(j);
    run_job("pass", j, 1'b0, none, w);
  endtask

  task automatic test_relu();
    job_t j, none;
    int w;
    j = '{func: 4'b0010, src: 8'h20, dst: 8'h80, len: 9'd3};
    none = j;
    acc_mem[8'h20] = 32'hFFFF_FFFF;
    acc_mem[8'h21] = 32'd12;
    acc_mem[8'h22] = 32'h8000_0000;
    drive_cmd(j);
    run_job("relu", j, 1'b0, none, w);
  endtask

  task automatic test_back_to_back();
    job_t j1, j2;
    int w;
    j1 = '{func: 4'b0001, src: 8'hFE, dst: 8'hFF, len: 9'd3};
    j2 = '{func: 4'b0010, src: 8'h30, dst: 8'h50, len: 9'd2};
    acc_mem[8'hFE] = 32'h1111_0001;
    acc_mem[8'hFF] = 32'h2222_0002;
    acc_mem[8'h00] = 32'h3333_0003;
    acc_mem[8'h30] = 32'hF000_0000;
    acc_mem[8'h31] = 32'd77;
    drive_cmd(j1);
    run_job("wrap", j1, 1'b1, j2, w);
    run_job("b2b", j2, 1'b0, j1, w);
    total++;
    if (w !== 0) begin
      bad++;
      $display("FAIL b2b_accept_cycle: got %0d extra wait cycles, want 0", w);
    end
  endtask

  task automatic test_degenerate();
    job_t j, none;
    int w;
    j = '{func: 4'b0001, src: 8'h05, dst: 8'h06, len: 9'd0};
    none = j;
    drive_cmd(j);
    run_job("len0", j, 1'b0, none, w);
    j = '{func: 4'b0011, src: 8'h05, dst: 8'h06, len: 9'd5};
    drive_cmd(j);
    run_job("badfunc", j, 1'b0, none, w);
  endtask

  task automatic test_reset_mid_job();
    job_t j;
    int w;
    j = '{func: 4'b0001, src: 8'h60, dst: 8'h70, len: 9'd10};
    drive_cmd(j);
    w = 0;
    while (!(bus.cmd_valid && bus.cmd_ready) && w < 60) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    total++;
    if ({bus.rd_en, bus.eu_en, bus.wr_en, bus.busy, bus.done, bus.err, bus.cmd_ready} !== 7'b0000001) begin
      bad++;
      $display("FAIL reset_abort: got {rd,eu,wr,busy,done,err,ready}=%b want 0000001",
               {bus.rd_en, bus.eu_en, bus.wr_en, bus.busy, bus.done, bus.err, bus.cmd_ready});
    end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      total++;
      if ({bus.rd_en, bus.wr_en, bus.done, bus.busy, bus.cmd_ready} !== 5'b00001) begin
        bad++;
        $display("FAIL after_abort cycle %0d: got {rd,wr,done,busy,ready}=%b want 00001", n,
                 {bus.rd_en, bus.wr_en, bus.done, bus.busy, bus.cmd_ready});
      end
    end
  endtask

  function automatic job_t rand_job();
    job_t j;
    logic [3:0] funcs [6];
    funcs = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
    j.func = funcs[$urandom_range(0, 5)];
    j.src  = AW'($urandom);
    j.dst  = AW'($urandom);
    j.len  = LW'($urandom_range(0, 12));
    return j;
  endfunction

  task automatic test_random();
    job_t cur, nxt;
    bit chain, prev_chain;
    int w;
    for (int i = 0; i < 256; i++) acc_mem[i] = $urandom;
    prev_chain = 1'b0;
    cur = rand_job();
    drive_cmd(cur);
    for (int k = 0; k < 24; k++) begin
      nxt = rand_job();
      chain = (k < 23) && ($urandom_range(0, 1) == 1);
      run_job("random", cur, chain, nxt, w);
      if (prev_chain) begin
        total++;
        if (w !== 0) begin
          bad++;
          $display("FAIL random_chain_accept job %0d: got %0d wait cycles, want 0", k, w);
        end
      end
      if (!chain && k < 23) drive_cmd(nxt);
      prev_chain = chain;
      cur = nxt;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_func  = 4'd0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    for (int i = 0; i < 256; i++) acc_mem[i] = 32'd0;
    test_reset();
    test_pass();
    test_relu();
    test_back_to_back();
    test_degenerate();
    test_reset_mid_job();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/elementwise_sequencer.md
Name: elementwise_sequencer

Overview:
- Command-driven controller for the post-accumulation elementwise stage.
- Accepts one job at a time: function code, source base, destination base, element count.
- Streams 32-bit signed words from the accumulator SRAM through the elementwise unit and writes the results to the unified buffer.
- Owns the elementwise unit's en/func/in inputs. The elementwise unit has a fixed 1-cycle registered latency and clears its output when en is low.

Parameters:
- AW, 8, address width of the accumulator SRAM and the unified buffer.
- LW, 9, width of the element-count field (maximum 2^LW-1 elements).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  sequencer can accept a command
- cmd_func  input  4  function code (4'b0001 pass, 4'b0010 ReLU)
- cmd_src  input  AW  accumulator base address
- cmd_dst  input  AW  unified-buffer base address
- cmd_len  input  LW  element count
- rd_en  output  1  accumulator SRAM read strobe
- rd_addr  output  AW  accumulator SRAM read address
- rd_data  input  32  accumulator read data, valid 1 cycle after rd_en
- eu_en  output  1  elementwise unit enable
- eu_func  output  4  elementwise unit function select
- eu_in  output  32  elementwise unit operand
- eu_out  input  32  elementwise unit result (1-cycle latency)
- wr_en  output  1  unified-buffer write strobe
- wr_addr  output  AW  unified-buffer write address
- wr_data  output  32  unified-buffer write data
- busy  output  1  job in progress
- done  output  1  1-cycle pulse at job completion
- err  output  1  qualifies done: job rejected for an unsupported func

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, all outputs 0 except cmd_ready=1; address counters and pipeline valid bits cleared.
- Reset mid-job aborts immediately. No further rd_en or wr_en occurs; in-flight elements are discarded.
- States: IDLE, READ, DRAIN, DONE.
- cmd_ready = (state==IDLE). A handshake (cmd_valid & cmd_ready) at posedge T latches func/src/dst/len.
- IDLE -> READ when the accepted len != 0 and func ∈ {0001, 0010}.
- IDLE -> DONE for len == 0, or for any other func. No reads or writes occur; err=1 with done only for an invalid func.
- READ: rd_en=1 for exactly len consecutive cycles, T+1 .. T+len. rd_addr = src+i for element i.
- READ -> DRAIN after the last read.
- Stage 1: in the cycle after rd_en, eu_in = rd_data (combinational pass), eu_en=1, eu_func = latched func.
- eu_en=0 whenever no valid element is in stage 1, so eu_out is 0 for bubbles.
- Stage 2: wr_en=1 in the cycle after eu_en. wr_data = eu_out, wr_addr = dst+i.
- Per element i: read at T+1+i, eu_en at T+2+i, write at T+3+i.
- DRAIN -> DONE after the last write (cycle T+2+len); state is DONE in cycle T+3+len.
- DONE: done=1 (plus err if applicable) for exactly one cycle, then IDLE.
- busy=1 in READ, DRAIN and DONE.
- A new command can be accepted the cycle after done. Throughput is 1 element/cycle; per-job overhead is 3 cycles.
- Addresses wrap modulo 2^AW: src=255, len=3 reads 255, 0, 1.
- cmd_valid while busy is ignored; the command must be held by the requester until accepted.
- Writes are always accepted (no back-pressure). The read and write ports are independent SRAMs, so overlapping ranges are not hazards.
- eu_func is held at the latched func throughout the job and returns to 0 in IDLE.

Test Plan:
- Reset mid-job: assert reset during READ -> all strobes 0 the same cycle; after release, state IDLE, cmd_ready=1, no done pulse.
- Pass job: func=0001, src=0x10, dst=0x40, len=4, SRAM[0x10..0x13] = {5, -7, 0, 0x7FFFFFFF}:
  - expect rd_en at T+1..T+4 and writes at T+3..T+6 to 0x40..0x43 with identical data;
  - expect done at T+7 with err=0.
- ReLU job: func=0010, len=3, data {-1, 12, 0x80000000} -> writes {0, 12, 0}; wr_en never asserted outside the 3 cycles.
- Wrap and back-to-back: src=0xFE, dst=0xFF, len=3 -> rd_addr 0xFE, 0xFF, 0x00 and wr_addr 0xFF, 0x00, 0x01. A second command held on cmd_valid is accepted only in the cycle after done.
- Degenerate commands:
  - len=0, func=0001 -> no rd_en, done at T+1 with err=0;
  - func=0011, len=5 -> no rd_en, done at T+1 with err=1.
